// File: rtl/conv33_seq.sv
// Frame sequencer: streams a W_IN x W_IN image from a three-port pixel memory into conv33
// and writes each valid window result to the output memory. `define CONV33_SEQ_PERF_EN adds perf_cycles.
module conv33_seq #(
    parameter int PIXEL_WIDTH = 8,
    parameter int W_IN        = 252,
    parameter int CONV_LAT    = 1,
    parameter int IN_AW       = $clog2(W_IN*W_IN),
    parameter int OUT_AW      = $clog2((W_IN-2)*(W_IN-2))
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode_in,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [IN_AW-1:0]       rd_addr_top,
    output logic [IN_AW-1:0]       rd_addr_mid,
    output logic [IN_AW-1:0]       rd_addr_bot,
    input  logic [PIXEL_WIDTH-1:0] rd_data_top,
    input  logic [PIXEL_WIDTH-1:0] rd_data_mid,
    input  logic [PIXEL_WIDTH-1:0] rd_data_bot,
    output logic                   conv_shift_en,
    output logic                   conv_row_clr_n,
    output logic [PIXEL_WIDTH-1:0] conv_pix_top,
    output logic [PIXEL_WIDTH-1:0] conv_pix_mid,
    output logic [PIXEL_WIDTH-1:0] conv_pix_bot,
    output logic [1:0]             conv_mode,
    input  logic [PIXEL_WIDTH-1:0] conv_pixel_out,
    output logic                   wr_en,
    output logic [OUT_AW-1:0]      wr_addr,
    output logic [PIXEL_WIDTH-1:0] wr_data
`ifdef CONV33_SEQ_PERF_EN
    ,
    output logic [31:0]            perf_cycles
`endif
);

    localparam int CW  = $clog2(W_IN);
    localparam int LCW = $clog2(CONV_LAT + 1) + 1;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CLEAR, S_DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]     col_q, row_q, sh_col_q;
    logic [LCW-1:0]    wait_q;
    logic [IN_AW-1:0]  in_base_q;
    logic [OUT_AW-1:0] out_base_q;
    logic [1:0]        mode_q;
    logic              aborted_q;
    logic              shift_q;
    logic [CONV_LAT-1:0] dl_v_q;
    logic [OUT_AW-1:0] dl_a_q [CONV_LAT];

    logic              last_col, last_row, wait_end, flush, dl_load;
    logic [IN_AW-1:0]  top_addr;

    assign last_col = (col_q == CW'(W_IN-1));
    assign last_row = (row_q == CW'(W_IN-3));
    assign wait_end = (wait_q == LCW'(CONV_LAT));
    // An abort kills anything still in flight towards the output memory, this cycle included.
    assign flush    = abort && ((state_q == S_READ) || (state_q == S_WAIT));
    assign dl_load  = shift_q && (sh_col_q >= CW'(2)) && !flush && !aborted_q;
    assign top_addr = in_base_q + IN_AW'(col_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  if (abort) state_d = S_CLEAR;
                     else if (last_col) state_d = S_WAIT;
            S_WAIT:  if (abort || wait_end) state_d = S_CLEAR;
            S_CLEAR: if (aborted_q || abort) state_d = S_IDLE;
                     else if (last_row) state_d = S_DONE;
                     else state_d = S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        rd_en          = (state_q == S_READ);
        conv_row_clr_n = (state_q != S_CLEAR);
    end

    // Row bases advance by running sums so no multiplier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            wait_q     <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            mode_q     <= '0;
            aborted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    mode_q     <= mode_in;
                    col_q      <= '0;
                    row_q      <= '0;
                    wait_q     <= '0;
                    in_base_q  <= '0;
                    out_base_q <= '0;
                    aborted_q  <= 1'b0;
                end
                S_READ:  col_q  <= last_col ? '0 : col_q + CW'(1);
                S_WAIT:  wait_q <= wait_q + LCW'(1);
                S_CLEAR: begin
                    wait_q <= '0;
                    if (state_d == S_READ) begin
                        row_q      <= row_q + CW'(1);
                        col_q      <= '0;
                        in_base_q  <= in_base_q + IN_AW'(W_IN);
                        out_base_q <= out_base_q + OUT_AW'(W_IN-2);
                    end
                end
                default: ;
            endcase
            if (flush) aborted_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= 1'b0;
            sh_col_q <= '0;
            dl_v_q   <= '0;
            for (int i = 0; i < CONV_LAT; i++) dl_a_q[i] <= '0;
        end else begin
            shift_q  <= rd_en;
            sh_col_q <= col_q;
            if (flush) begin
                dl_v_q <= '0;
            end else begin
                dl_v_q[0] <= dl_load;
                for (int i = 1; i < CONV_LAT; i++) dl_v_q[i] <= dl_v_q[i-1];
            end
            dl_a_q[0] <= out_base_q + OUT_AW'(sh_col_q) - OUT_AW'(2);
            for (int i = 1; i < CONV_LAT; i++) dl_a_q[i] <= dl_a_q[i-1];
        end
    end

    assign rd_addr_top   = rd_en ? top_addr : '0;
    assign rd_addr_mid   = rd_en ? top_addr + IN_AW'(W_IN) : '0;
    assign rd_addr_bot   = rd_en ? top_addr + IN_AW'(2*W_IN) : '0;
    assign conv_shift_en = shift_q;
    assign conv_pix_top  = shift_q ? rd_data_top : '0;
    assign conv_pix_mid  = shift_q ? rd_data_mid : '0;
    assign conv_pix_bot  = shift_q ? rd_data_bot : '0;
    assign conv_mode     = mode_q;
    assign wr_en         = dl_v_q[CONV_LAT-1] && !flush;
    assign wr_addr       = wr_en ? dl_a_q[CONV_LAT-1] : '0;
    assign wr_data       = wr_en ? conv_pixel_out : '0;

`ifdef CONV33_SEQ_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           perf_q <= '0;
        else if ((state_q == S_IDLE) && start) perf_q <= '0;
        else if (busy)                        perf_q <= perf_q + 32'd1;
    end
    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv33_seq.sv
// Bench for conv33_seq: memory and conv33 stand-ins, event scoreboard with cycle-exact expectations.
module tb_conv33_seq;

    localparam int W   = 6;
    localparam int LAT = 1;
    localparam int P   = W + LAT + 2;
    localparam int IAW = $clog2(W*W);
    localparam int OAW = $clog2((W-2)*(W-2));

    logic           clk = 1'b0;
    logic           rst_n, start, abort;
    logic [1:0]     mode_in;
    logic           busy, done, rd_en;
    logic [IAW-1:0] rd_addr_top, rd_addr_mid, rd_addr_bot;
    logic [7:0]     rd_data_top, rd_data_mid, rd_data_bot;
    logic           conv_shift_en, conv_row_clr_n;
    logic [7:0]     conv_pix_top, conv_pix_mid, conv_pix_bot;
    logic [1:0]     conv_mode;
    logic [7:0]     conv_pixel_out;
    logic           wr_en;
    logic [OAW-1:0] wr_addr;
    logic [7:0]     wr_data;

    conv33_seq #(.PIXEL_WIDTH(8), .W_IN(W), .CONV_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_in(mode_in),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_top(rd_addr_top), .rd_addr_mid(rd_addr_mid), .rd_addr_bot(rd_addr_bot),
        .rd_data_top(rd_data_top), .rd_data_mid(rd_data_mid), .rd_data_bot(rd_data_bot),
        .conv_shift_en(conv_shift_en), .conv_row_clr_n(conv_row_clr_n),
        .conv_pix_top(conv_pix_top), .conv_pix_mid(conv_pix_mid), .conv_pix_bot(conv_pix_bot),
        .conv_mode(conv_mode), .conv_pixel_out(conv_pixel_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- memory and conv33 stand-ins ----------------
    logic [7:0] img [64];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_top <= img[rd_addr_top];
            rd_data_mid <= img[rd_addr_mid];
            rd_data_bot <= img[rd_addr_bot];
        end
    end

    // Index 0 holds the newest column. Mode 0 passes the centre; other modes add two corners.
    logic [7:0] wt [3], wm [3], wb [3];
    always @(posedge clk) begin
        if (!conv_row_clr_n) begin
            for (int i = 0; i < 3; i++) begin
                wt[i] <= 8'd0; wm[i] <= 8'd0; wb[i] <= 8'd0;
            end
        end else if (conv_shift_en) begin
            wt[2] <= wt[1]; wt[1] <= wt[0]; wt[0] <= conv_pix_top;
            wm[2] <= wm[1]; wm[1] <= wm[0]; wm[0] <= conv_pix_mid;
            wb[2] <= wb[1]; wb[1] <= wb[0]; wb[0] <= conv_pix_bot;
        end
    end
    always_comb conv_pixel_out = (conv_mode == 2'd0) ? wm[1] : 8'(wt[2] + wb[0]);

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];
    logic [63:0] rd_q [$];
    int clr_q [$];
    int done_q [$];
    logic [1:0] exp_mode = 2'd0;
    int wr_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model(input logic [1:0] mode, input int r, input int oc);
        if (mode == 2'd0) return img[(r+1)*W + oc + 1];
        return 8'(img[r*W + oc] + img[(r+2)*W + oc + 2]);
    endfunction

    // kind 0: complete frame; 1: abort in cycle lim; 2: reset asserted late in cycle lim.
    task automatic push_frame(input int t0, input logic [1:0] mode, input int kind, input int lim);
        int base, cy;
        for (int r = 0; r <= W-3; r++) begin
            base = t0 + r*P;
            for (int c = 0; c < W; c++) begin
                cy = base + 1 + c;
                if (kind == 0 || cy <= lim) rd_q.push_back({32'(cy), 32'(r*W + c)});
            end
            for (int c = 2; c < W; c++) begin
                cy = base + 2 + c + LAT;
                if (kind == 0 || (kind == 1 && cy < lim) || (kind == 2 && cy <= lim))
                    exp_q.push_back({32'(cy), 16'(r*(W-2) + c - 2), 16'(model(mode, r, c-2))});
            end
            cy = base + P;
            if (kind == 0 || (kind == 1 && cy < lim) || (kind == 2 && cy <= lim)) clr_q.push_back(cy);
        end
        if (kind == 1) clr_q.push_back(lim + 1);
        if (kind == 0) done_q.push_back(t0 + 1 + (W-2)*P);
    endtask

    logic [63:0] mon_e, mon_r;
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) check("wr_unexp", wr_en, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("wr_cyc", cyc, mon_e[63:32]);
                    check("wr_addr", wr_addr, mon_e[31:16]);
                    check("wr_data", wr_data, mon_e[15:0]);
                end
            end
            if (rd_en) begin
                if (rd_q.size() == 0) check("rd_unexp", rd_en, 0);
                else begin
                    mon_r = rd_q.pop_front();
                    check("rd_cyc", cyc, mon_r[63:32]);
                    check("rd_top", rd_addr_top, mon_r[31:0]);
                    check("rd_mid", rd_addr_mid, mon_r[31:0] + W);
                    check("rd_bot", rd_addr_bot, mon_r[31:0] + 2*W);
                end
            end
            if (!conv_row_clr_n) begin
                if (clr_q.size() == 0) check("clr_unexp", conv_row_clr_n, 1);
                else check("clr_cyc", cyc, clr_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) check("done_unexp", done, 0);
                else check("done_cyc", cyc, done_q.pop_front());
            end
            if (busy) check("mode", conv_mode, exp_mode);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_top"}, rd_addr_top, 0);
        check({tag, "_rd_mid"}, rd_addr_mid, 0);
        check({tag, "_rd_bot"}, rd_addr_bot, 0);
        check({tag, "_shift"}, conv_shift_en, 0);
        check({tag, "_clr_n"}, conv_row_clr_n, 1);
        check({tag, "_pix"}, {conv_pix_top, conv_pix_mid, conv_pix_bot}, 0);
        check({tag, "_mode"}, conv_mode, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_wr_left"}, exp_q.size(), 0);
        check({tag, "_rd_left"}, rd_q.size(), 0);
        check({tag, "_clr_left"}, clr_q.size(), 0);
        check({tag, "_done_left"}, done_q.size(), 0);
    endtask

    // Called at a negedge while the DUT is idle.
    task automatic start_frame(input logic [1:0] mode, input int kind, input int lim_off, output int t0);
        t0 = cyc;
        start = 1'b1;
        mode_in = mode;
        exp_mode = mode;
        wr_cnt = 0;
        push_frame(t0, mode, kind, t0 + lim_off);
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", busy, 1);
    endtask

    task automatic finish_frame(input string tag, input int t0);
        wait_until(t0 + 2 + (W-2)*P);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_wr_count"}, wr_cnt, (W-2)*(W-2));
        check_drained(tag);
    endtask

    task automatic randomize_img();
        for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    // ---------------- sequence ----------------
    int t0;
    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode_in = 2'd0;
        randomize_img();
        repeat (4) @(negedge clk);
        check_idle("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
        end
        check_idle("idle");

        // full frame, mode 1, random image
        start_frame(2'd1, 0, 0, t0);
        finish_frame("full", t0);

        // ramp image, pass mode, mode_in disturbed mid-frame
        for (int i = 0; i < 64; i++) img[i] = 8'(i);
        start_frame(2'd0, 0, 0, t0);
        wait_until(t0 + 10);
        mode_in = 2'd3;
        finish_frame("ramp", t0);
        mode_in = 2'd0;

        // abort during row 2, column 5
        randomize_img();
        start_frame(2'd2, 1, 1 + 5 + 2*P, t0);
        wait_until(t0 + 5 + 2*P);
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk); #1 check("abort_wr", wr_en, 0);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_idle", busy, 0);
        repeat (5) @(negedge clk);
        check_drained("abort");

        // normal frame after abort
        start_frame(2'($urandom_range(0, 3)), 0, 0, t0);
        finish_frame("post_abort", t0);

        // reset during the WAIT of row 1
        randomize_img();
        start_frame(2'd3, 2, P + W + 1, t0);
        wait_until(t0 + P + W + 1);
        #2 rst_n = 1'b0;
        #1 check_idle("rst_mid");
        @(negedge clk);
        #2 rst_n = 1'b1;
        exp_mode = 2'd0;
        repeat (20) @(negedge clk);
        check_drained("rst_mid");

        // start pulsed while busy is ignored
        randomize_img();
        start_frame(2'd1, 0, 0, t0);
        wait_until(t0 + 3);
        start = 1'b1;
        mode_in = 2'd2;
        @(negedge clk);
        start = 1'b0;
        mode_in = 2'd0;
        finish_frame("illegal_start", t0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
